// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between the instruction-fetch (I)
// and load/store (D) requesters. D has fixed priority, but after
// STARVE_LIMIT consecutive lost conflicts I wins the next one.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        m_valid,
  output logic        m_we,
  output logic [2:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } sel_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  sel_t       sel;
  logic [3:0] starve_cnt;

  // Transaction sequencing, arbitration and read-data capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      sel        <= SEL_I;
      starve_cnt <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req && d_req) begin
            if (starve_cnt >= LIMIT) begin
              sel        <= SEL_I;
              starve_cnt <= '0;
            end else begin
              sel <= SEL_D;
              if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
            end
            state <= ISSUE;
          end else if (i_req) begin
            sel        <= SEL_I;
            starve_cnt <= '0;
            state      <= ISSUE;
          end else if (d_req) begin
            sel   <= SEL_D;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_ready) begin
            if (sel == SEL_I)  i_rdata <= m_rdata;
            else if (!d_we)    d_rdata <= m_rdata;
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory request fields are steered from the selected requester while issuing.
  always_comb begin
    m_valid = 1'b0;
    m_we    = 1'b0;
    m_size  = '0;
    m_addr  = '0;
    m_wdata = '0;
    if (state == ISSUE) begin
      m_valid = 1'b1;
      if (sel == SEL_I) begin
        m_size = 3'b010;
        m_addr = i_addr;
      end else begin
        m_we    = d_we;
        m_size  = d_size;
        m_addr  = d_addr;
        m_wdata = d_wdata;
      end
    end
  end

  // Done pulses and busy decode directly from registered state.
  always_comb begin
    i_done = (state == RESP) && (sel == SEL_I);
    d_done = (state == RESP) && (sel == SEL_D);
    busy   = (state != IDLE) || i_req || d_req;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the core's instruction-fetch requester (I) and load/store requester (D), for the shared-memory build of the riscv core.
- Sequences each transaction through idle, issue and response phases.
- Gives D fixed priority, with an anti-starvation limit so I always makes progress.
- Drives `busy` so the core can stall.

Parameters:
- STARVE_LIMIT, 4: consecutive I losses in arbitration after which I wins the next conflict. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous active-low reset; sampled on rising edge of clk
- i_req  in  1  fetch request; held with i_addr stable until i_done
- i_addr  in  32  fetch address
- i_rdata  out  32  fetched word; registered, valid from i_done cycle until next I completion
- i_done  out  1  one-cycle pulse: fetch complete
- d_req  in  1  data request; held with d_* inputs stable until d_done
- d_we  in  1  1 = store, 0 = load
- d_size  in  3  access size code, passed through to m_size (funct3 encoding)
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_rdata  out  32  load data; registered, valid from d_done cycle until next D load completion
- d_done  out  1  one-cycle pulse: data access complete
- m_valid  out  1  memory request valid
- m_we  out  1  memory write enable
- m_size  out  3  memory access size
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data; valid when m_ready=1
- m_ready  in  1  memory accepts/completes the request this cycle
- busy  out  1  state != IDLE, or (i_req | d_req) pending

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, sel=I, starve_cnt=0.
  - i_rdata=0, d_rdata=0, i_done=0, d_done=0.
  - m_valid=0; m_we/m_size/m_addr/m_wdata=0.
  - Applies mid-transaction: any outstanding memory request is abandoned with no done pulse.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: latch sel to that requester, go to ISSUE.
  - Both requests: sel=I if starve_cnt>=STARVE_LIMIT, else sel=D. Go to ISSUE.
  - starve_cnt: increments (saturating) when both request and D wins; clears when I is selected.
  - starve_cnt is unchanged in every other case.
- ISSUE:
  - m_valid=1. m_addr/m_we/m_size/m_wdata driven combinationally from the selected requester's inputs.
  - For I: m_we=0, m_size=3'b010, m_wdata=0.
  - m_ready=0: stay in ISSUE; outputs hold.
  - m_ready=1: capture m_rdata into i_rdata (sel=I) or d_rdata (sel=D, d_we=0), then go to RESP.
  - A D store leaves d_rdata unchanged.
- RESP:
  - m_valid=0.
  - Pulse i_done or d_done (per sel) for exactly one cycle, then go to IDLE.
  - Requesters may drop or change req from the cycle after done. The arbiter does not sample req during RESP, so no duplicate issue occurs.
- Timing:
  - Latency from req first seen in IDLE to done is 2 + N cycles, where N = cycles of m_ready=0 in ISSUE. Zero-wait memory gives done 2 cycles after req.
  - Throughput is at most one transaction per 3 cycles.
- Exclusivity: i_done and d_done are never high together; m_valid is high only in ISSUE.
- A requester dropping req while its transaction is in ISSUE is illegal; the arbiter still completes it.
- Outputs i_done, d_done and m_valid are glitch-free decodes of registered state.

Test Plan:
- Reset: hold reset=0 for 2 cycles with i_req=d_req=1 -> m_valid=0, i_done=d_done=0, i_rdata=d_rdata=0, busy=1 (reqs pending). Release -> first m_valid 1 cycle later, with m_addr=d_addr (D priority).
- Single fetch, zero-wait: i_req=1, i_addr=0x100, m_ready=1, m_rdata=0x00500093 -> m_valid for 1 cycle with m_addr=0x100, m_we=0, m_size=2. i_done pulses 2 cycles after req; i_rdata=0x00500093.
- Store with 3 wait states: d_req=1, d_we=1, d_size=0, d_addr=0x2004, d_wdata=0xAB. m_ready low 3 cycles then high -> m_valid high 4 cycles with fields stable. d_done at cycle 5; d_rdata unchanged.
- Starvation, STARVE_LIMIT=4: i_req and d_req both held continuously, m_ready=1 -> grant order D,D,D,D,I,D,D,D,D,I. starve_cnt clears after each I grant.
- Reset mid-ISSUE: start a D load, m_ready=0, assert reset=0 for one cycle -> m_valid=0 next cycle, no d_done ever for that access, state IDLE. The arbiter re-arbitrates afterwards.
- Back-to-back loads: D requester re-presents a new d_addr the cycle after d_done -> next m_valid exactly 2 cycles after the previous d_done; each d_rdata matches its own m_rdata.
